// File: rtl/dma_frontend_pkg.sv
// Shared definitions for the cluster DMA frontend register file: register map,
// conf/status field positions and the backend descriptor layout.
package dma_frontend_pkg;

   localparam logic [5:0] RegSrcLo    = 6'h00;
   localparam logic [5:0] RegSrcHi    = 6'h04;
   localparam logic [5:0] RegDstLo    = 6'h08;
   localparam logic [5:0] RegDstHi    = 6'h0C;
   localparam logic [5:0] RegNumBytes = 6'h10;
   localparam logic [5:0] RegNextId   = 6'h18;
   localparam logic [5:0] RegDoneId   = 6'h20;
   localparam logic [5:0] RegStatus   = 6'h28;

   localparam int unsigned ConfDecouple  = 0;
   localparam int unsigned ConfDeburst   = 1;
   localparam int unsigned ConfSerialize = 2;
   localparam int unsigned ConfIrqEn     = 3;
   localparam logic [3:0]  ConfReset     = 4'b0001;

   localparam int unsigned StatusFillLsb = 24;
   localparam int unsigned StatusBusyBit = 16;

   // Addresses are carried at 64 bits; the upper half stays zero when AddrWidth=32.
   typedef struct packed {
      logic [63:0] src_addr;
      logic [63:0] dst_addr;
      logic [31:0] num_bytes;
      logic        decouple;
      logic        deburst;
      logic        serialize;
   } transf_descr_t;

   function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dma_frontend_queued_regs_fifo.sv
// Synchronous FIFO (common_cells fifo_v3 interface subset) holding backend descriptors.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DEPTH        = 4,
   parameter type         dtype        = logic,
   parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   output logic                full_o,
   output logic                empty_o,
   output logic [ADDR_DEPTH:0] usage_o,
   input  dtype                data_i,
   input  logic                push_i,
   output dtype                data_o,
   input  logic                pop_i
);

   localparam logic [ADDR_DEPTH:0]   FullCnt = (ADDR_DEPTH + 1)'(DEPTH);
   localparam logic [ADDR_DEPTH-1:0] LastIdx = ADDR_DEPTH'(DEPTH - 1);

   logic [ADDR_DEPTH-1:0] rd_q, wr_q;
   logic [ADDR_DEPTH:0]   cnt_q;
   dtype                  mem_q [DEPTH];
   logic                  is_empty, bypass, push_ok, pop_ok;

   always_comb begin
      is_empty = (cnt_q == '0);
      bypass   = FALL_THROUGH && is_empty && push_i && pop_i;
      push_ok  = push_i && (cnt_q != FullCnt) && !bypass;
      pop_ok   = pop_i && !is_empty;
      full_o   = (cnt_q == FullCnt);
      empty_o  = is_empty && !(FALL_THROUGH && push_i);
      usage_o  = cnt_q;
      data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_q];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= (wr_q == LastIdx) ? '0 : wr_q + ADDR_DEPTH'(1);
         end
         if (pop_ok) rd_q <= (rd_q == LastIdx) ? '0 : rd_q + ADDR_DEPTH'(1);
         cnt_q <= cnt_q + (ADDR_DEPTH + 1)'(push_ok) - (ADDR_DEPTH + 1)'(pop_ok);
      end
   end

endmodule

// File: rtl/dma_frontend_queued_regs.sv
// TCDM-mapped DMA frontend register file: staging registers, descriptor queue,
// transfer-ID generation and completion counting toward one backend port.
module dma_frontend_queued_regs
   import dma_frontend_pkg::*;
#(
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned QueueDepth = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          ctrl_req_i,
   input  logic          ctrl_type_i,
   input  logic [3:0]    ctrl_be_i,
   input  logic [31:0]   ctrl_add_i,
   input  logic [31:0]   ctrl_data_i,
   output logic          ctrl_gnt_o,
   output logic          ctrl_valid_o,
   output logic [31:0]   ctrl_data_o,
   output logic          be_valid_o,
   input  logic          be_ready_i,
   input  logic          be_done_i,
   output transf_descr_t transf_descr_o,
   output logic          irq_o
);

   localparam bit          HasHi  = (AddrWidth == 64);
   localparam int unsigned UsageW = ((QueueDepth > 1) ? $clog2(QueueDepth) : 1) + 1;

   logic [31:0]       src_lo_q, src_hi_q, dst_lo_q, dst_hi_q, len_q;
   logic [31:0]       next_id_q, done_id_q, rdata_q, rdata_d, status;
   logic [3:0]        conf_q;
   logic              rvalid_q, irq_q;
   logic [5:0]        reg_off;
   logic              is_enq, push, gnt, wr_en, rd_en, busy;
   logic              q_full, q_empty;
   logic [UsageW-1:0] q_usage;
   transf_descr_t     push_descr;
   logic              unused_addr;

   assign unused_addr = ^ctrl_add_i[31:6];

   always_comb begin
      reg_off = ctrl_add_i[5:0];
      is_enq  = ctrl_req_i && ctrl_type_i && (reg_off == RegNextId);
      // A full queue refuses the launch even if the backend pops in the same cycle.
      push    = is_enq && !q_full;
      gnt     = ctrl_req_i && !(is_enq && q_full);
      wr_en   = gnt && !ctrl_type_i;
      rd_en   = gnt && ctrl_type_i;
      busy    = !q_empty || ((next_id_q - 32'd1) != done_id_q);

      status                         = '0;
      status[StatusFillLsb +: 8]     = 8'(q_usage);
      status[StatusBusyBit]          = busy;
      status[3:0]                    = conf_q;

      rdata_d = '0;
      case (reg_off)
         RegSrcLo:    rdata_d = src_lo_q;
         RegSrcHi:    rdata_d = src_hi_q;
         RegDstLo:    rdata_d = dst_lo_q;
         RegDstHi:    rdata_d = dst_hi_q;
         RegNumBytes: rdata_d = len_q;
         RegNextId:   rdata_d = next_id_q;
         RegDoneId:   rdata_d = done_id_q;
         RegStatus:   rdata_d = status;
         default:     rdata_d = '0;
      endcase

      push_descr.src_addr  = {src_hi_q, src_lo_q};
      push_descr.dst_addr  = {dst_hi_q, dst_lo_q};
      push_descr.num_bytes = len_q;
      push_descr.decouple  = conf_q[ConfDecouple];
      push_descr.deburst   = conf_q[ConfDeburst];
      push_descr.serialize = conf_q[ConfSerialize];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_lo_q  <= '0;
         src_hi_q  <= '0;
         dst_lo_q  <= '0;
         dst_hi_q  <= '0;
         len_q     <= '0;
         conf_q    <= ConfReset;
         next_id_q <= 32'd1;
         done_id_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         rvalid_q  <= gnt;
         rdata_q   <= rd_en ? rdata_d : '0;
         irq_q     <= be_done_i & conf_q[ConfIrqEn];
         done_id_q <= done_id_q + 32'(be_done_i);
         if (push) next_id_q <= next_id_q + 32'd1;
         if (wr_en) begin
            case (reg_off)
               RegSrcLo:    src_lo_q <= apply_be(src_lo_q, ctrl_data_i, ctrl_be_i);
               RegSrcHi:    if (HasHi) src_hi_q <= apply_be(src_hi_q, ctrl_data_i, ctrl_be_i);
               RegDstLo:    dst_lo_q <= apply_be(dst_lo_q, ctrl_data_i, ctrl_be_i);
               RegDstHi:    if (HasHi) dst_hi_q <= apply_be(dst_hi_q, ctrl_data_i, ctrl_be_i);
               RegNumBytes: len_q    <= apply_be(len_q, ctrl_data_i, ctrl_be_i);
               RegStatus:   if (ctrl_be_i[0]) conf_q <= ctrl_data_i[3:0];
               default:     ;
            endcase
         end
      end
   end

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DEPTH        (QueueDepth),
      .dtype        (transf_descr_t)
   ) i_queue (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .full_o  (q_full),
      .empty_o (q_empty),
      .usage_o (q_usage),
      .data_i  (push_descr),
      .push_i  (push),
      .data_o  (transf_descr_o),
      .pop_i   (be_valid_o && be_ready_i)
   );

   assign ctrl_gnt_o   = gnt;
   assign ctrl_valid_o = rvalid_q;
   assign ctrl_data_o  = rdata_q;
   assign be_valid_o   = !q_empty;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_dma_frontend_queued_regs.sv
// Directed + randomized bench for dma_frontend_queued_regs against a queue-based model.
module tb_dma_frontend_queued_regs;
   import dma_frontend_pkg::*;

   localparam int unsigned QD = 4;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          ctrl_req_i = 1'b0, ctrl_type_i = 1'b0, be_ready_i = 1'b0, be_done_i = 1'b0;
   logic [3:0]    ctrl_be_i = '0;
   logic [31:0]   ctrl_add_i = '0, ctrl_data_i = '0;
   logic          ctrl_gnt_o, ctrl_valid_o, be_valid_o, irq_o;
   logic [31:0]   ctrl_data_o;
   transf_descr_t transf_descr_o;
   logic          gnt32, valid32, bev32, irq32;
   logic [31:0]   data32;
   transf_descr_t descr32;

   int unsigned checks = 0, errors = 0;

   logic [31:0]   m_src_lo, m_src_hi, m_dst_lo, m_dst_hi, m_len, m_next, m_done;
   logic [3:0]    m_conf;
   transf_descr_t q[$];

   always #5 clk = ~clk;

   dma_frontend_queued_regs #(.AddrWidth(64), .QueueDepth(QD)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .ctrl_req_i(ctrl_req_i), .ctrl_type_i(ctrl_type_i),
      .ctrl_be_i(ctrl_be_i), .ctrl_add_i(ctrl_add_i), .ctrl_data_i(ctrl_data_i),
      .ctrl_gnt_o(ctrl_gnt_o), .ctrl_valid_o(ctrl_valid_o), .ctrl_data_o(ctrl_data_o),
      .be_valid_o(be_valid_o), .be_ready_i(be_ready_i), .be_done_i(be_done_i),
      .transf_descr_o(transf_descr_o), .irq_o(irq_o));

   dma_frontend_queued_regs #(.AddrWidth(32), .QueueDepth(QD)) dut32 (
      .clk_i(clk), .rst_ni(rst_ni), .ctrl_req_i(ctrl_req_i), .ctrl_type_i(ctrl_type_i),
      .ctrl_be_i(ctrl_be_i), .ctrl_add_i(ctrl_add_i), .ctrl_data_i(ctrl_data_i),
      .ctrl_gnt_o(gnt32), .ctrl_valid_o(valid32), .ctrl_data_o(data32),
      .be_valid_o(bev32), .be_ready_i(be_ready_i), .be_done_i(be_done_i),
      .transf_descr_o(descr32), .irq_o(irq32));

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input transf_descr_t obs, input transf_descr_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_src_lo = '0; m_src_hi = '0; m_dst_lo = '0; m_dst_hi = '0; m_len = '0;
      m_conf = 4'b0001; m_next = 32'd1; m_done = '0;
      q.delete();
   endtask

   function automatic transf_descr_t mk_descr();
      transf_descr_t d;
      d.src_addr  = {m_src_hi, m_src_lo};
      d.dst_addr  = {m_dst_hi, m_dst_lo};
      d.num_bytes = m_len;
      d.decouple  = m_conf[0];
      d.deburst   = m_conf[1];
      d.serialize = m_conf[2];
      return d;
   endfunction

   function automatic transf_descr_t narrow(input transf_descr_t d);
      transf_descr_t r;
      r = d;
      r.src_addr[63:32] = '0;
      r.dst_addr[63:32] = '0;
      return r;
   endfunction

   function automatic logic [31:0] mread(input logic [5:0] a, input bit wide);
      logic        busy;
      logic [31:0] st;
      busy = (q.size() != 0) || ((m_next - 32'd1) != m_done);
      st   = {8'(q.size()), 7'b0, busy, 12'b0, m_conf};
      case (a)
         6'h00:   return m_src_lo;
         6'h04:   return wide ? m_src_hi : 32'h0;
         6'h08:   return m_dst_lo;
         6'h0C:   return wide ? m_dst_hi : 32'h0;
         6'h10:   return m_len;
         6'h18:   return m_next;
         6'h20:   return m_done;
         6'h28:   return st;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_v & ~mask) | (d & mask);
   endfunction

   task automatic mwrite(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      case (a)
         6'h00: m_src_lo = merge(m_src_lo, d, be);
         6'h04: m_src_hi = merge(m_src_hi, d, be);
         6'h08: m_dst_lo = merge(m_dst_lo, d, be);
         6'h0C: m_dst_hi = merge(m_dst_hi, d, be);
         6'h10: m_len    = merge(m_len, d, be);
         6'h28: if (be[0]) m_conf = d[3:0];
         default: ;
      endcase
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be,
                            input string tag);
      logic [31:0] hi;
      @(negedge clk);
      hi = $urandom();
      ctrl_req_i = 1'b1; ctrl_type_i = 1'b0; ctrl_add_i = {hi[31:6], a};
      ctrl_be_i = be; ctrl_data_i = d; be_ready_i = 1'b0;
      #1;
      chk1({tag, "_gnt"}, ctrl_gnt_o, 1'b1);
      chk1({tag, "_gnt32"}, gnt32, 1'b1);
      @(negedge clk);
      ctrl_req_i = 1'b0;
      chk1({tag, "_valid"}, ctrl_valid_o, 1'b1);
      chk32({tag, "_wdata"}, ctrl_data_o, 32'h0);
      chk1({tag, "_valid32"}, valid32, 1'b1);
      mwrite(a, d, be);
   endtask

   task automatic bus_read(input logic [5:0] a, input bit rdy, input string tag);
      logic [31:0] exp, exp32, hi;
      bit          enq, g, popd;
      @(negedge clk);
      hi = $urandom();
      ctrl_req_i = 1'b1; ctrl_type_i = 1'b1; ctrl_add_i = {hi[31:6], a};
      ctrl_be_i = '0; ctrl_data_i = $urandom(); be_ready_i = rdy;
      exp   = mread(a, 1'b1);
      exp32 = mread(a, 1'b0);
      enq   = (a == 6'h18);
      g     = !(enq && (q.size() == QD));
      popd  = rdy && (q.size() != 0);
      #1;
      chk1({tag, "_gnt"}, ctrl_gnt_o, g);
      chk1({tag, "_gnt32"}, gnt32, g);
      chk1({tag, "_bev_pre"}, be_valid_o, q.size() != 0);
      if (popd) chkd({tag, "_pop_descr"}, transf_descr_o, q[0]);
      @(negedge clk);
      ctrl_req_i = 1'b0; be_ready_i = 1'b0;
      if (popd) q.delete(0);
      if (g && enq) begin
         q.push_back(mk_descr());
         m_next = m_next + 32'd1;
      end
      chk1({tag, "_valid"}, ctrl_valid_o, g);
      chk32({tag, "_rdata"}, ctrl_data_o, g ? exp : 32'h0);
      chk1({tag, "_valid32"}, valid32, g);
      chk32({tag, "_rdata32"}, data32, g ? exp32 : 32'h0);
      chk1({tag, "_bev_post"}, be_valid_o, q.size() != 0);
   endtask

   task automatic pop_one(input string tag);
      @(negedge clk);
      chk1({tag, "_bev"}, be_valid_o, 1'b1);
      chkd({tag, "_descr"}, transf_descr_o, q[0]);
      chkd({tag, "_descr32"}, descr32, narrow(q[0]));
      @(negedge clk);
      chkd({tag, "_stall_descr"}, transf_descr_o, q[0]);
      be_ready_i = 1'b1;
      @(negedge clk);
      be_ready_i = 1'b0;
      q.delete(0);
      chk1({tag, "_bev32"}, bev32, q.size() != 0);
   endtask

   task automatic done_pulse(input string tag);
      @(negedge clk);
      be_done_i = 1'b1;
      @(negedge clk);
      be_done_i = 1'b0;
      m_done = m_done + 32'd1;
      chk1({tag, "_irq"}, irq_o, m_conf[3]);
      chk1({tag, "_irq32"}, irq32, m_conf[3]);
      @(negedge clk);
      chk1({tag, "_irq_end"}, irq_o, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [5:0]  addrs [5];
      logic [5:0]  a;
      logic [31:0] pending;
      addrs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10};
      model_reset();

      // 1: reset state
      repeat (3) @(negedge clk);
      chk1("rst_bev", be_valid_o, 1'b0);
      chk1("rst_irq", irq_o, 1'b0);
      chk1("rst_valid", ctrl_valid_o, 1'b0);
      chk1("rst_gnt", ctrl_gnt_o, 1'b0);
      chk32("rst_data", ctrl_data_o, 32'h0);
      chk1("rst_bev32", bev32, 1'b0);
      rst_ni = 1'b1;
      bus_read(6'h28, 1'b0, "rst_status");
      bus_read(6'h20, 1'b0, "rst_done");

      // 2: first launch
      bus_write(6'h00, 32'h0000_1000, 4'hF, "w_src");
      bus_write(6'h08, 32'h0000_2000, 4'hF, "w_dst");
      bus_write(6'h10, 32'd64, 4'hF, "w_len");
      bus_read(6'h18, 1'b0, "enq_first");
      pop_one("pop_first");

      // 3: fill the queue with random descriptors, then overflow
      for (int i = 0; i < QD; i++) begin
         bus_write(6'h00, $urandom(), 4'hF, "w_src_r");
         bus_write(6'h04, $urandom(), 4'hF, "w_srchi_r");
         bus_write(6'h08, $urandom(), 4'hF, "w_dst_r");
         bus_write(6'h10, $urandom(), 4'hF, "w_len_r");
         bus_read(6'h18, 1'b0, "enq_fill");
      end
      bus_read(6'h18, 1'b0, "enq_full");
      bus_read(6'h28, 1'b0, "status_full");
      bus_read(6'h18, 1'b1, "enq_full_pop");
      bus_read(6'h18, 1'b0, "enq_retry");
      while (q.size() != 0) pop_one("drain");

      // 4: byte enables and hi registers
      bus_write(6'h00, 32'h0000_AB00, 4'b0010, "w_byte");
      bus_read(6'h00, 1'b0, "r_byte");
      for (int i = 0; i < 8; i++) begin
         a = addrs[$urandom_range(0, 4)];
         bus_write(a, $urandom(), 4'($urandom_range(0, 15)), "w_rand");
         bus_read(a, 1'b0, "r_rand");
      end
      bus_read(6'h0C, 1'b0, "r_dsthi");
      bus_read(6'h34, 1'b0, "r_unmapped");
      bus_write(6'h18, 32'hDEAD_BEEF, 4'hF, "w_nextid");

      // 5: conf snapshot per descriptor, completions and irq
      bus_write(6'h28, 32'h0000_0006, 4'b0001, "w_conf6");
      for (int i = 0; i < 3; i++) bus_read(6'h18, 1'b0, "enq_conf");
      bus_write(6'h28, 32'h0000_0008, 4'b0001, "w_conf8");
      bus_write(6'h28, 32'h0000_000F, 4'b1110, "w_conf_nobe");
      bus_read(6'h28, 1'b0, "status_busy");
      while (q.size() != 0) pop_one("drain_conf");
      pending = m_next - 32'd1 - m_done;
      for (int unsigned i = 0; i < pending; i++) done_pulse("done");
      bus_read(6'h20, 1'b0, "r_done");
      bus_read(6'h28, 1'b0, "status_idle");

      // 6: ID wrap, then reset with a full queue
      @(negedge clk);
      force dut.next_id_q = 32'hFFFF_FFFE;
      force dut32.next_id_q = 32'hFFFF_FFFE;
      #1;
      release dut.next_id_q;
      release dut32.next_id_q;
      m_next = 32'hFFFF_FFFE;
      for (int i = 0; i < QD; i++) bus_read(6'h18, 1'b0, "enq_wrap");
      bus_read(6'h28, 1'b0, "status_wrap");
      #2;
      rst_ni = 1'b0;
      #1;
      model_reset();
      chk1("midrst_bev", be_valid_o, 1'b0);
      chk1("midrst_valid", ctrl_valid_o, 1'b0);
      @(negedge clk);
      rst_ni = 1'b1;
      bus_read(6'h28, 1'b0, "post_rst_status");
      bus_read(6'h18, 1'b0, "post_rst_enq");
      bus_read(6'h20, 1'b0, "post_rst_done");
      pop_one("post_rst_pop");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
